// File: rtl/lcd_scanout_if.sv
// Frame buffer read port and front/back buffer swap handshake between
// the scanout engine (master) and the frame buffer / writer side (slave).
interface lcd_scanout_if;
    logic [14:0] fb_addr;
    logic [1:0]  fb_dout;
    logic        rd_buf;
    logic        swap_req;
    logic        swap_ack;

    modport master (output fb_addr, rd_buf, swap_ack, input fb_dout, swap_req);
    modport slave  (input fb_addr, rd_buf, swap_ack, output fb_dout, swap_req);
endinterface

// File: rtl/lcd_scanout.sv
// Scans a 160x144 2-bit frame buffer out to a 640x480@60 raster with 3x
// replication, and owns the display/write buffer swap at start of vblank.
module lcd_scanout #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned SCALE      = 3,
    parameter int unsigned IMG_W      = 160,
    parameter int unsigned IMG_H      = 144,
    parameter int unsigned X_OFF      = 80,
    parameter int unsigned Y_OFF      = 24,
    parameter logic [11:0] BORDER_RGB = 12'h000
) (
    input  logic          clk,
    input  logic          rst,
    lcd_scanout_if.master fb,
    output logic          frame_start,
    output logic          hsync_n,
    output logic          vsync_n,
    output logic          active,
    output logic [11:0]   rgb
);
    localparam int unsigned CW      = 10;
    localparam int unsigned AW      = 15;
    localparam int unsigned XW      = 8;
    localparam int unsigned SW      = 2;
    localparam int unsigned RW      = 12;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_LO    = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_HI    = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_LO    = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_HI    = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] X_LO     = CW'(X_OFF);
    localparam logic [CW-1:0] X_HI     = CW'(X_OFF + IMG_W * SCALE);
    localparam logic [CW-1:0] X_LAST   = CW'(X_OFF + IMG_W * SCALE - 1);
    localparam logic [CW-1:0] Y_LO     = CW'(Y_OFF);
    localparam logic [CW-1:0] Y_HI     = CW'(Y_OFF + IMG_H * SCALE);
    localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);
    localparam logic [AW-1:0] ROW_STEP = AW'(IMG_W);

    logic [CW-1:0] h_count, v_count;
    logic [XW-1:0] src_x;
    logic [SW-1:0] sx_sub, sy_sub;
    logic [AW-1:0] row_base;
    logic          win_d1, win_d2, act_d1, act_d2;
    logic          hs_d1, hs_d2, vs_d1, vs_d2;

    logic          h_last_c, v_last_c, in_x_c, in_y_c, in_win_c, act_c;
    logic          hs_c, vs_c, x_end_c, swap_c;
    logic [RW-1:0] pal_c;

    // Raster decode in the counter domain
    assign h_last_c = (h_count == H_LAST);
    assign v_last_c = (v_count == V_LAST);
    assign in_x_c   = (h_count >= X_LO) && (h_count < X_HI);
    assign in_y_c   = (v_count >= Y_LO) && (v_count < Y_HI);
    assign in_win_c = in_x_c && in_y_c;
    assign x_end_c  = (h_count == X_LAST);
    assign act_c    = (h_count < H_VIS) && (v_count < V_VIS);
    assign hs_c     = (h_count >= HS_LO) && (h_count < HS_HI);
    assign vs_c     = (v_count >= VS_LO) && (v_count < VS_HI);
    assign swap_c   = (h_count == '0) && (v_count == V_VIS);

    always_comb begin
        pal_c = 12'hFFF;
        case (fb.fb_dout)
            2'd1:    pal_c = 12'hAAA;
            2'd2:    pal_c = 12'h555;
            2'd3:    pal_c = 12'h000;
            default: pal_c = 12'hFFF;
        endcase
    end

    // Raster counters and multiplier-free address generation
    always_ff @(posedge clk) begin
        if (!rst) begin
            h_count    <= '0;
            v_count    <= '0;
            src_x      <= '0;
            sx_sub     <= '0;
            sy_sub     <= '0;
            row_base   <= '0;
            fb.fb_addr <= '0;
        end else begin
            h_count <= h_last_c ? '0 : h_count + 1'b1;
            if (h_last_c) begin
                v_count <= v_last_c ? '0 : v_count + 1'b1;
            end

            if (!in_x_c) begin
                src_x  <= '0;
                sx_sub <= '0;
            end else if (sx_sub == SUB_LAST) begin
                src_x  <= src_x + 1'b1;
                sx_sub <= '0;
            end else begin
                sx_sub <= sx_sub + 1'b1;
            end

            // row_base tracks 160*src_y; it steps once per SCALE window lines
            if (!in_y_c) begin
                sy_sub   <= '0;
                row_base <= '0;
            end else if (x_end_c) begin
                if (sy_sub == SUB_LAST) begin
                    sy_sub   <= '0;
                    row_base <= row_base + ROW_STEP;
                end else begin
                    sy_sub <= sy_sub + 1'b1;
                end
            end

            if (in_win_c) begin
                fb.fb_addr <= row_base + AW'(src_x);
            end
        end
    end

    // Delay line keeping sync/active/window aligned with the frame buffer read
    always_ff @(posedge clk) begin
        if (!rst) begin
            win_d1  <= 1'b0;
            win_d2  <= 1'b0;
            act_d1  <= 1'b0;
            act_d2  <= 1'b0;
            hs_d1   <= 1'b1;
            hs_d2   <= 1'b1;
            vs_d1   <= 1'b1;
            vs_d2   <= 1'b1;
            active  <= 1'b0;
            hsync_n <= 1'b1;
            vsync_n <= 1'b1;
            rgb     <= '0;
        end else begin
            win_d1  <= in_win_c;
            win_d2  <= win_d1;
            act_d1  <= act_c;
            act_d2  <= act_d1;
            hs_d1   <= ~hs_c;
            hs_d2   <= hs_d1;
            vs_d1   <= ~vs_c;
            vs_d2   <= vs_d1;
            active  <= act_d2;
            hsync_n <= hs_d2;
            vsync_n <= vs_d2;
            rgb     <= act_d2 ? (win_d2 ? pal_c : BORDER_RGB) : '0;
        end
    end

    // Frame marker and buffer swap, sampled only at the first vblank cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_start <= 1'b0;
            fb.swap_ack <= 1'b0;
            fb.rd_buf   <= 1'b0;
        end else begin
            frame_start <= (h_count == '0) && (v_count == '0);
            fb.swap_ack <= swap_c && fb.swap_req;
            if (swap_c && fb.swap_req) begin
                fb.rd_buf <= ~fb.rd_buf;
            end
        end
    end
endmodule

// File: tb/tb_lcd_scanout.sv
// Checks lcd_scanout against an arithmetic raster model: one instance with the
// standard 640x480 timing and one with a 14-line frame to reach several vblanks.
module tb_lcd_scanout;
    localparam int F_VA = 480, F_VS0 = 490, F_VT = 525, F_YOFF = 24, F_IMGH = 144;
    localparam int S_VA = 10, S_VFP = 1, S_VSW = 2, S_VBP = 1;
    localparam int S_VT = S_VA + S_VFP + S_VSW + S_VBP;
    localparam int S_YOFF = 2, S_IMGH = 2;

    logic        clk, rst, swap_req;
    logic        frame_start_f, hsync_n_f, vsync_n_f, active_f;
    logic        frame_start_s, hsync_n_s, vsync_n_s, active_s;
    logic [11:0] rgb_f, rgb_s;

    int          n = 0, total = 0, bad = 0, t;
    logic [14:0] addr_f = '0, addr_s = '0;
    logic        rd_f = 1'b0, rd_s = 1'b0, ack_f = 1'b0, ack_s = 1'b0;

    lcd_scanout_if bus_f ();
    lcd_scanout_if bus_s ();
    assign bus_f.swap_req = swap_req;
    assign bus_s.swap_req = swap_req;

    lcd_scanout dut_f (
        .clk(clk), .rst(rst), .fb(bus_f.master),
        .frame_start(frame_start_f), .hsync_n(hsync_n_f), .vsync_n(vsync_n_f),
        .active(active_f), .rgb(rgb_f)
    );

    lcd_scanout #(
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VSW), .V_BP(S_VBP),
        .IMG_H(S_IMGH), .Y_OFF(S_YOFF)
    ) dut_s (
        .clk(clk), .rst(rst), .fb(bus_s.master),
        .frame_start(frame_start_s), .hsync_n(hsync_n_s), .vsync_n(vsync_n_s),
        .active(active_s), .rgb(rgb_s)
    );

    // Frame buffer contents: each word holds the low two bits of its address
    always @(posedge clk) begin
        bus_f.fb_dout <= bus_f.fb_addr[1:0];
        bus_s.fb_dout <= bus_s.fb_addr[1:0];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit in_win(int m, int vt, int yoff, int imgh);
        int h, v;
        h = m % 800;
        v = (m / 800) % vt;
        return (h >= 80) && (h < 560) && (v >= yoff) && (v < yoff + 3 * imgh);
    endfunction

    function automatic int addr_of(int m, int vt, int yoff);
        int h, v;
        h = m % 800;
        v = (m / 800) % vt;
        return ((v - yoff) / 3) * 160 + (h - 80) / 3;
    endfunction

    // Expected pins n cycles after release: frame_start from state n-1, video from n-3
    function automatic logic [32:0] expect_pins(int n_i, int va, int vs0, int vt, int yoff,
                                                int imgh, logic [14:0] addr, logic rd, logic ack);
        int m, h, v;
        logic fs, hs, vs, act;
        logic [11:0] col;
        fs  = (n_i >= 1) && (((n_i - 1) % (800 * vt)) == 0);
        hs  = 1'b1;
        vs  = 1'b1;
        act = 1'b0;
        col = 12'h000;
        if (n_i >= 3) begin
            m   = n_i - 3;
            h   = m % 800;
            v   = (m / 800) % vt;
            hs  = !((h >= 656) && (h < 752));
            vs  = !((v >= vs0) && (v < vs0 + 2));
            act = (h < 640) && (v < va);
            if (act && in_win(m, vt, yoff, imgh)) begin
                case (addr_of(m, vt, yoff) % 4)
                    0:       col = 12'hFFF;
                    1:       col = 12'hAAA;
                    2:       col = 12'h555;
                    default: col = 12'h000;
                endcase
            end
        end
        return {fs, hs, vs, act, col, addr, rd, ack};
    endfunction

    task automatic chk(string tag, logic [32:0] obs, logic [32:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
        end
    endtask

    task automatic directed();
        case (n)
            1:              chk("frame_start_after_release", 33'(frame_start_f), 33'(1));
            658:            chk("hsync_before_fall", 33'(hsync_n_f), 33'(1));
            659:            chk("hsync_first_fall", 33'(hsync_n_f), 33'(0));
            754:            chk("hsync_last_low", 33'(hsync_n_f), 33'(0));
            755:            chk("hsync_rise", 33'(hsync_n_f), 33'(1));
            24 * 800 + 81:  chk("l24_addr_h80", 33'(bus_f.fb_addr), 33'(0));
            24 * 800 + 84:  chk("l24_addr_h83", 33'(bus_f.fb_addr), 33'(1));
            24 * 800 + 560: chk("l24_addr_h559", 33'(bus_f.fb_addr), 33'(159));
            24 * 800 + 82:  chk("l24_rgb_h79_border", 33'(rgb_f), 33'(12'h000));
            24 * 800 + 83:  chk("l24_rgb_h80", 33'(rgb_f), 33'(12'hFFF));
            24 * 800 + 86:  chk("l24_rgb_h83", 33'(rgb_f), 33'(12'hAAA));
            24 * 800 + 563: chk("l24_rgb_h560_border", 33'(rgb_f), 33'(12'h000));
            26 * 800 + 81:  chk("l26_addr_start", 33'(bus_f.fb_addr), 33'(0));
            27 * 800 + 81:  chk("l27_addr_start", 33'(bus_f.fb_addr), 33'(160));
            8001:           chk("swap0_rd_ack", 33'({bus_s.rd_buf, bus_s.swap_ack}), 33'(2'b11));
            8002:           chk("swap0_ack_end", 33'({bus_s.rd_buf, bus_s.swap_ack}), 33'(2'b10));
            19201:          chk("no_swap_frame1", 33'({bus_s.rd_buf, bus_s.swap_ack}), 33'(2'b10));
            default:        ;
        endcase
    endtask

    // One clock: update the model with what this edge samples, then compare
    task automatic cyc();
        @(posedge clk);
        if (!rst) begin
            n      = 0;
            addr_f = '0;
            addr_s = '0;
            rd_f   = 1'b0;
            rd_s   = 1'b0;
            ack_f  = 1'b0;
            ack_s  = 1'b0;
        end else begin
            if (in_win(n, F_VT, F_YOFF, F_IMGH)) addr_f = 15'(addr_of(n, F_VT, F_YOFF));
            if (in_win(n, S_VT, S_YOFF, S_IMGH)) addr_s = 15'(addr_of(n, S_VT, S_YOFF));
            ack_f = swap_req && ((n % (800 * F_VT)) == 800 * F_VA);
            ack_s = swap_req && ((n % (800 * S_VT)) == 800 * S_VA);
            rd_f  = rd_f ^ ack_f;
            rd_s  = rd_s ^ ack_s;
            n++;
        end
        @(negedge clk);
        chk("full_pins",
            {frame_start_f, hsync_n_f, vsync_n_f, active_f, rgb_f, bus_f.fb_addr,
             bus_f.rd_buf, bus_f.swap_ack},
            expect_pins(n, F_VA, F_VS0, F_VT, F_YOFF, F_IMGH, addr_f, rd_f, ack_f));
        chk("short_pins",
            {frame_start_s, hsync_n_s, vsync_n_s, active_s, rgb_s, bus_s.fb_addr,
             bus_s.rd_buf, bus_s.swap_ack},
            expect_pins(n, S_VA, S_VA + S_VFP, S_VT, S_YOFF, S_IMGH, addr_s, rd_s, ack_s));
        directed();
    endtask

    initial begin
        rst      = 1'b0;
        swap_req = 1'b0;
        repeat (5) cyc();
        rst = 1'b1;

        // Frame 0: request mid-frame, held until acknowledged at vblank
        while (n < 3200) cyc();
        swap_req = 1'b1;
        while ((n < 8010) && !bus_s.swap_ack) cyc();
        chk("ack_arrival", 33'(n), 33'(8001));
        swap_req = 1'b0;

        // Frame 1: random short requests well before vblank must not swap
        while (n < 11200 + 7200) begin
            swap_req = ($urandom_range(0, 15) == 0);
            cyc();
        end
        swap_req = 1'b0;

        // Frames 2-3: request raised at a random point and held high
        t = 22400 + int'($urandom_range(0, 7000));
        while (n < t) cyc();
        swap_req = 1'b1;

        // Frame 4: reset mid-frame with rd_buf=1 and a request still pending
        while (n < 44800 + 4000 + 300) cyc();
        rst = 1'b0;
        repeat (int'($urandom_range(3, 8))) cyc();
        rst = 1'b1;
        while (n < 2000) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lcd_scanout.md
Name: lcd_scanout

Overview:
- Reads the 160x144 LCD frame buffer and drives a 640x480@60 VGA-style raster with 3x integer scaling, centred in the frame.
- The frame buffer holds 2-bit shades and is written by the mode 3 pixel path.
- Owns the double-buffer swap handshake, so the writer never tears a frame being displayed.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync pulse width
H_BP, 48, horizontal back porch (line total 800)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync pulse width
V_BP, 33, vertical back porch (frame total 525)
SCALE, 3, pixel/line replication factor
X_OFF, 80, first h_count of image window
Y_OFF, 24, first v_count of image window
BORDER_RGB, 12'h000, colour outside image window

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous reset, active-low
fb_addr  out  15  frame buffer read address (x + 160*y)
fb_dout  in  2  frame buffer read data, valid 1 cycle after fb_addr
rd_buf  out  1  frame buffer half being displayed; writer targets ~rd_buf
swap_req  in  1  level; writer has finished a frame in ~rd_buf
swap_ack  out  1  one-cycle pulse: swap performed
frame_start  out  1  one-cycle pulse at h_count=0, v_count=0
hsync_n  out  1  active-low hsync
vsync_n  out  1  active-low vsync
active  out  1  visible region (h<H_ACTIVE, v<V_ACTIVE)
rgb  out  12  4:4:4 colour

Behaviour:
- Reset (rst=0 at posedge): h_count=0, v_count=0, fb_addr=0, rd_buf=0, swap_ack=0, frame_start=0, hsync_n=1, vsync_n=1, active=0, rgb=0. Pipeline registers cleared. Reset mid-frame aborts the frame; the raster restarts at h=0, v=0 on the first cycle after release.
- Counters: h_count 0..799 wraps to 0 and increments v_count. v_count 0..524 wraps to 0.
- Image window: X_OFF <= h < X_OFF+160*SCALE (80..559) and Y_OFF <= v < Y_OFF+144*SCALE (24..455).
- Address generation, no multiplier:
  - src_x counts 0..159 with a sub-counter 0..SCALE-1; it advances every SCALE cycles inside the window and resets to 0 at window start.
  - src_y counts 0..143 with a line sub-counter; it advances every SCALE lines at the end of the window.
  - row_base holds 160*src_y and increases by 160 when src_y advances. It is 0 at frame start.
  - fb_addr = row_base + src_x, registered. Outside the window fb_addr holds its last value. Max address is 23039.
- Pipeline, fixed latency PIPE=3 from counter state to pins:
  - t: counters.
  - t+1: fb_addr valid.
  - t+2: fb_dout valid.
  - t+3: rgb registered.
  - hsync_n, vsync_n, active and the in-window flag are delayed by 3 stages so all pins stay aligned.
- Palette: shade 0->12'hFFF, 1->12'hAAA, 2->12'h555, 3->12'h000.
  - rgb = palette(fb_dout) in window.
  - rgb = BORDER_RGB when active but outside the window.
  - rgb = 0 when not active.
- Sync (counter domain, before delay):
  - hsync_n=0 for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync_n=0 for v in 490..491.
- frame_start: undelayed, counter domain, high for the single cycle h=0, v=0.
- Swap handshake:
  - Sampled only at h=0, v=V_ACTIVE (start of vblank).
  - If swap_req=1 there: rd_buf toggles next cycle and swap_ack pulses high for exactly that same cycle.
  - swap_req asserted at any other time is held pending until the next vblank sample.
  - The writer must deassert swap_req after seeing swap_ack. A swap_req still high at the following vblank triggers another swap.
  - rd_buf never changes during lines 0..479.

Test Plan:
- Reset: hold rst=0 for 5 cycles, then release -> all outputs at reset values; frame_start=1 on the first cycle after release; first hsync_n fall 656 cycles after release plus 3 (PIPE).
- Line 24 addressing: fb model returns addr[1:0] -> fb_addr sequence 0,0,0,1,1,1,... 159 over h=80..559. rgb pins lag by 3 cycles and show FFF,FFF,FFF,AAA,AAA,AAA,... rgb=BORDER_RGB at h=79 and h=560 (delayed), rgb=0 at h>=640.
- Line replication: lines 24,25,26 all start at fb_addr=0, line 27 starts at 160. Last window line (455) starts at 22880 and ends at 23039. Line 456 shows border.
- Sync widths: hsync_n low exactly 96 cycles per line. vsync_n low exactly 2 lines (1600 cycles). Frame period exactly 420000 cycles.
- Swap: raise swap_req at v=100 -> no change until h=0, v=480. Then rd_buf 0->1 with swap_ack one cycle. Drop swap_req on ack -> no swap next frame. Hold swap_req high -> rd_buf 1->0 the next frame.
- Mid-frame reset: assert rst=0 at v=200, h=300 while rd_buf=1 and swap_req pending -> rd_buf=0, no swap_ack, raster restarts at 0,0, fb_addr=0.
